interrupt_controller: RTL
=========================

Name: interrupt_controller

Overview:
- Parametrised interrupt controller for the CPU core; replaces raw per-line interrupt wiring with N latched request channels.
- Holds the IF (flag) and IE (enable) registers, memory-mapped on the CPU bus, plus the master enable IME, with the one-instruction EI delay.
- Gives the control path a prioritised request, a channel id and a vector address, and a wake signal for HALT.

Parameters:
- NUM_IRQ, 5, number of request channels; legal range 1..8.
- VECTOR_BASE, 16'h0040, vector address of channel 0.
- VECTOR_STRIDE, 8, address distance between consecutive channel vectors.
- IF_ADDR, 16'hFF0F, bus address of the IF register.
- IE_ADDR, 16'hFFFF, bus address of the IE register.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- irq_in  in  NUM_IRQ  raw request lines; bit 0 is the highest priority.
- addr  in  16  CPU bus address (MAR).
- wdata  in  8  CPU write data.
- we  in  1  CPU write strobe.
- re  in  1  CPU read strobe.
- rdata  out  8  register read data.
- rdata_en  out  1  high when rdata must drive the bus (re asserted and addr hits IF_ADDR or IE_ADDR).
- ei  in  1  EI executed (pulse).
- di  in  1  DI executed (pulse).
- reti  in  1  RETI executed (pulse).
- instr_done  in  1  instruction-boundary pulse from the control path.
- irq_req  out  1  interrupt dispatch request.
- irq_id  out  3  index of the highest-priority pending channel.
- irq_vector  out  16  dispatch address.
- irq_ack  in  1  control path has begun dispatch (pulse).
- wake  out  1  any enabled flag pending, ignoring IME; releases HALT.

Behaviour:
- Reset (rst high at a clock edge): IF=0, IE=8'h00, IME=0, ei_pend=0, and irq_prev loads the current irq_in, so a line already high at reset release raises no request. While rst is high, all outputs are 0.
- Edge detect: a channel edge is irq_in[i] & ~irq_prev[i]. irq_prev updates every cycle. The edge sets IF[i] at the same clock edge; IF[i] is visible the following cycle. A held-high line sets IF only once.
- Register map, IF: IF[NUM_IRQ-1:0] is stored. A read returns 1s in the unimplemented upper bits, e.g. 8'hE0|IF for NUM_IRQ=5. A write loads wdata[NUM_IRQ-1:0].
- Register map, IE: IE is a full 8-bit read/write register. Only IE[NUM_IRQ-1:0] gates requests.
- Reads: rdata is combinational. When rdata_en is low, rdata=8'h00.
- Same-cycle priority on an IF bit, highest first:
  - an edge on that bit sets it;
  - then a CPU write to IF loads it;
  - then irq_ack clears IF[irq_id].
- pending = IF & IE[NUM_IRQ-1:0]. All outputs below are combinational from registered state.
  - wake = |pending.
  - irq_req = IME & |pending.
  - irq_id = lowest set index of pending; 0 when pending is 0.
  - irq_vector = VECTOR_BASE + irq_id*VECTOR_STRIDE, computed modulo 2^16.
- IME control:
  - di: clears IME and ei_pend at the next edge.
  - ei: sets ei_pend. IME then becomes 1 at the edge of the first instr_done strictly after the EI cycle. If ei and instr_done arrive in the same cycle, IME sets at the next instr_done. ei while IME is already 1 has no effect.
  - reti: sets IME at the next edge with no delay.
  - Simultaneous di and ei: di wins. Simultaneous reti and di: di wins.
- irq_ack:
  - Acting case (irq_req=1): clears IF[irq_id] for the currently presented id, and clears IME and ei_pend at the same edge.
  - Ignored case (irq_req=0): no effect.
- Latency: a line rising in cycle N gives irq_req high in cycle N+1, provided IE and IME are set.
- NUM_IRQ<8: irq_in bits and IE bits above NUM_IRQ-1 never influence irq_req, wake or irq_id.
- Bus decode: a we or re to an address other than IF_ADDR/IE_ADDR is ignored.

Test Plan:
- Reset with irq_in=5'b00001 held high, then rst low -> IF stays 0, irq_req=0; read of IF_ADDR returns 8'hE0.
- IE=8'h1F, IME=1 via reti; pulse irq_in[2] and irq_in[4] together -> next cycle irq_req=1, irq_id=2, irq_vector=16'h0050. After irq_ack: IF=5'b10000, IME=0, irq_req=0.
- IE=8'h1F, IF=5'b00100; pulse ei, then instr_done two cycles later -> irq_req stays 0 until the edge of that instr_done, then rises. A di issued before the instr_done keeps irq_req at 0.
- Same-cycle CPU write IF=8'h00 and a rising edge on irq_in[1] -> IF reads back 8'hE2.
- IME=0, IE=8'h01, edge on irq_in[0] -> wake=1, irq_req=0. Write IE=8'h00 -> wake=0.
- NUM_IRQ=8, VECTOR_BASE=16'hFFF0, VECTOR_STRIDE=8, IE=8'h80, IME=1, edge on irq_in[7] -> irq_id=7, irq_vector=16'h0028 (wraps modulo 2^16).

Source files
------------

// File: rtl/interrupt_controller.sv
// Interrupt controller: edge-latched request flags (IF), enables (IE), master enable (IME)
// with the one-instruction EI delay, priority encoding, vector generation and HALT wake.
module interrupt_controller #(
    parameter int unsigned NUM_IRQ       = 5,
    parameter logic [15:0] VECTOR_BASE   = 16'h0040,
    parameter int unsigned VECTOR_STRIDE = 8,
    parameter logic [15:0] IF_ADDR       = 16'hFF0F,
    parameter logic [15:0] IE_ADDR       = 16'hFFFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [15:0]        addr,
    input  logic [7:0]         wdata,
    input  logic               we,
    input  logic               re,
    output logic [7:0]         rdata,
    output logic               rdata_en,
    input  logic               ei,
    input  logic               di,
    input  logic               reti,
    input  logic               instr_done,
    output logic               irq_req,
    output logic [2:0]         irq_id,
    output logic [15:0]        irq_vector,
    input  logic               irq_ack,
    output logic               wake
);

    logic [NUM_IRQ-1:0] r_if;
    logic [NUM_IRQ-1:0] r_irq_prev;
    logic [7:0]         r_ie;
    logic               r_ime;
    logic               r_ei_pend;

    logic [NUM_IRQ-1:0] w_if_d;
    logic [7:0]         w_ie_d;
    logic               w_ime_d;
    logic               w_ei_pend_d;
    logic [NUM_IRQ-1:0] w_edge;
    logic [NUM_IRQ-1:0] w_pending;
    logic [2:0]         w_id;
    logic               w_any;
    logic               w_req;
    logic               w_ack_act;
    logic               w_hit_if;
    logic               w_hit_ie;
    logic [7:0]         w_if_rd;
    logic [15:0]        w_vector;

    assign w_edge    = irq_in & ~r_irq_prev;
    assign w_pending = r_if & r_ie[NUM_IRQ-1:0];
    assign w_any     = |w_pending;
    assign w_req     = r_ime & w_any;
    assign w_ack_act = irq_ack & w_req;
    assign w_hit_if  = (addr == IF_ADDR);
    assign w_hit_ie  = (addr == IE_ADDR);
    assign w_vector  = VECTOR_BASE + 16'(VECTOR_STRIDE * 32'(w_id));

    // Lowest set index wins; scanning downward leaves it as the final assignment.
    always_comb begin
        w_id = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_pending[i]) begin
                w_id = 3'(i);
            end
        end
    end

    // Unimplemented IF bits read as 1.
    always_comb begin
        w_if_rd              = 8'hFF;
        w_if_rd[NUM_IRQ-1:0] = r_if;
    end

    // IF next state: ack clear, then bus write, then edge set (highest priority applied last).
    always_comb begin
        w_if_d = r_if;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (w_ack_act && (w_id == 3'(i))) begin
                w_if_d[i] = 1'b0;
            end
        end
        if (we && w_hit_if) begin
            w_if_d = wdata[NUM_IRQ-1:0];
        end
        w_if_d = w_if_d | w_edge;
    end

    always_comb begin
        w_ie_d = r_ie;
        if (we && w_hit_ie) begin
            w_ie_d = wdata;
        end
    end

    // IME: later assignments take precedence, so di is applied last.
    always_comb begin
        w_ime_d     = r_ime;
        w_ei_pend_d = r_ei_pend;
        if (r_ei_pend && instr_done) begin
            w_ime_d     = 1'b1;
            w_ei_pend_d = 1'b0;
        end
        if (ei && !r_ime) begin
            w_ei_pend_d = 1'b1;
        end
        if (reti) begin
            w_ime_d = 1'b1;
        end
        if (w_ack_act) begin
            w_ime_d     = 1'b0;
            w_ei_pend_d = 1'b0;
        end
        if (di) begin
            w_ime_d     = 1'b0;
            w_ei_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_if       <= '0;
            r_ie       <= 8'h00;
            r_ime      <= 1'b0;
            r_ei_pend  <= 1'b0;
            r_irq_prev <= irq_in;
        end else begin
            r_if       <= w_if_d;
            r_ie       <= w_ie_d;
            r_ime      <= w_ime_d;
            r_ei_pend  <= w_ei_pend_d;
            r_irq_prev <= irq_in;
        end
    end

    always_comb begin
        rdata_en   = 1'b0;
        rdata      = 8'h00;
        irq_req    = 1'b0;
        irq_id     = 3'd0;
        irq_vector = 16'h0000;
        wake       = 1'b0;
        if (!rst) begin
            rdata_en   = re & (w_hit_if | w_hit_ie);
            irq_req    = w_req;
            irq_id     = w_id;
            irq_vector = w_vector;
            wake       = w_any;
            if (rdata_en) begin
                rdata = w_hit_if ? w_if_rd : r_ie;
            end
        end
    end

endmodule
